// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: FSM state encoding,
// opcode format constants and the legal range of program memory latency.
// Optional feature macro: FETCH_HALT_DETECT_EN (enables the HALT opcode).
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int FETCH_AW = 8;
    localparam int FETCH_DW = 8;

    // Bit of the opcode that marks a two-byte instruction.
    localparam int LONG_OPC_BIT = FETCH_DW - 1;

    // Opcode treated as HALT when halt detection is compiled in.
    localparam logic [FETCH_DW-1:0] HALT_OPC = 8'hFF;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 3;

    typedef enum logic [2:0] {
        IDLE,
        OP_REQ,
        OP_WAIT,
        ARG_REQ,
        ARG_WAIT,
        HOLD,
        HALTED
    } state_t;

    // Value loaded into the latency counter on a read strobe; out-of-range
    // latencies are clamped so the 2-bit counter can never be overloaded.
    function automatic logic [1:0] latLoadValue(input int lat);
        int clamped;
        clamped = lat;
        if (clamped < MEM_LAT_MIN) clamped = MEM_LAT_MIN;
        if (clamped > MEM_LAT_MAX) clamped = MEM_LAT_MAX;
        return 2'(clamped - 1);
    endfunction

endpackage

// File: rtl/fetch_lat_cnt.sv
// ----------------------------------------------------------------------------
// fetch_lat_cnt
// Counts the program memory read latency after each read strobe and flags
// the cycle in which the read data is valid.
// Ports:
//   clk_i    - system clock
//   reset_ni - synchronous active-low reset
//   load_i   - read strobe; starts a new count of MEM_LAT cycles
//   clear_i  - abandons any outstanding count
//   last_o   - high in the cycle the memory data is valid
// ----------------------------------------------------------------------------
module fetch_lat_cnt
    import fetch_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic load_i,
    input  logic clear_i,
    output logic last_o
);

    localparam logic [1:0] LoadValue = latLoadValue(MEM_LAT);

    logic [1:0] count_q, count_d;
    logic       busy_q, busy_d;

    // Clear beats load so a read strobe coinciding with an abort is dropped.
    always_comb begin
        count_d = count_q;
        busy_d  = busy_q;
        if (clear_i) begin
            count_d = 2'd0;
            busy_d  = 1'b0;
        end else if (load_i) begin
            count_d = LoadValue;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            if (count_q == 2'd0) begin
                busy_d = 1'b0;
            end else begin
                count_d = count_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            count_q <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    // The busy bit distinguishes a finished count from an idle zero.
    assign last_o = busy_q && (count_q == 2'd0);

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Reads 1- or 2-byte instructions from synchronous program memory at the
// program counter, presents them to the execute stage with a valid/ready
// handshake and pulses done_o once per byte consumed so the PC advances.
// A flush (PC being loaded over UART) aborts the fetch and silences done_o.
// Optional feature macro: FETCH_HALT_DETECT_EN - opcode HALT_OPC stops the
// fetcher in HALTED without advancing the PC; adds output halted_o.
// Ports:
//   clk_i, reset_ni   - clock, synchronous active-low reset
//   run_i             - fetch enable (sampled in IDLE and at handshake)
//   flush_i           - abort request while the PC is being loaded
//   pc_val_i          - current program counter
//   mem_rdata_i       - program memory read data
//   mem_addr_o        - program memory address
//   mem_en_o          - one-cycle read strobe
//   instr_o           - {opcode, operand}, operand 0 for short instructions
//   instr_valid_o     - instr_o holds a complete instruction
//   exec_ready_i      - execute stage accepts instr_o
//   done_o            - one-cycle PC increment pulse
//   halted_o          - (FETCH_HALT_DETECT_EN only) HALT accepted
// ----------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int AW      = FETCH_AW,
    parameter int DW      = FETCH_DW,
    parameter int MEM_LAT = 1
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            run_i,
    input  logic            flush_i,
    input  logic [AW-1:0]   pc_val_i,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic [AW-1:0]   mem_addr_o,
    output logic            mem_en_o,
    output logic [2*DW-1:0] instr_o,
    output logic            instr_valid_o,
    input  logic            exec_ready_i,
    output logic            done_o
`ifdef FETCH_HALT_DETECT_EN
    ,
    output logic            halted_o
`endif
);

    state_t          state_q;
    logic [AW-1:0]   mem_addr_q;
    logic            mem_en_q;
    logic [DW-1:0]   opcode_q;
    logic [DW-1:0]   operand_q;
    logic            instr_valid_q;
    logic            done_q;
    logic            latLast;
`ifdef FETCH_HALT_DETECT_EN
    logic            haltSeen_q;
    logic            halted_q;
`endif

    fetch_lat_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .load_i   (mem_en_q),
        .clear_i  (flush_i),
        .last_o   (latLast)
    );

    // Request states hold off while done_q is high: the PC only advances on
    // the edge that ends the DONE cycle, so waiting one cycle guarantees the
    // operand address is read from the already-incremented PC.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            mem_en_q      <= 1'b0;
            opcode_q      <= '0;
            operand_q     <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            haltSeen_q    <= 1'b0;
            halted_q      <= 1'b0;
`endif
        end else if (flush_i) begin
            state_q       <= IDLE;
            mem_en_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            haltSeen_q    <= 1'b0;
            halted_q      <= 1'b0;
`endif
        end else begin
            mem_en_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run_i) state_q <= OP_REQ;
                end
                OP_REQ, ARG_REQ: begin
                    if (!done_q) begin
                        mem_addr_q <= pc_val_i;
                        mem_en_q   <= 1'b1;
                        state_q    <= (state_q == OP_REQ) ? OP_WAIT : ARG_WAIT;
                    end
                end
                OP_WAIT: begin
                    if (latLast) begin
                        opcode_q <= mem_rdata_i;
`ifdef FETCH_HALT_DETECT_EN
                        if (mem_rdata_i == HALT_OPC) begin
                            operand_q     <= '0;
                            haltSeen_q    <= 1'b1;
                            instr_valid_q <= 1'b1;
                            state_q       <= HOLD;
                        end else
`endif
                        begin
                            done_q <= 1'b1;
                            if (mem_rdata_i[LONG_OPC_BIT]) begin
                                state_q <= ARG_REQ;
                            end else begin
                                operand_q     <= '0;
                                instr_valid_q <= 1'b1;
                                state_q       <= HOLD;
                            end
                        end
                    end
                end
                ARG_WAIT: begin
                    if (latLast) begin
                        operand_q     <= mem_rdata_i;
                        done_q        <= 1'b1;
                        instr_valid_q <= 1'b1;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (exec_ready_i) begin
                        instr_valid_q <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
                        if (haltSeen_q) begin
                            halted_q <= 1'b1;
                            state_q  <= HALTED;
                        end else
`endif
                        state_q <= run_i ? OP_REQ : IDLE;
                    end
                end
`ifdef FETCH_HALT_DETECT_EN
                HALTED: begin
                    state_q <= HALTED;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr_o    = mem_addr_q;
    assign mem_en_o      = mem_en_q;
    assign instr_o       = {opcode_q, operand_q};
    assign instr_valid_o = instr_valid_q;
    // A PC load must never coincide with an increment, even when the abort
    // arrives in the cycle right after a capture.
    assign done_o        = done_q && !flush_i;
`ifdef FETCH_HALT_DETECT_EN
    assign halted_o      = halted_q;
`endif

endmodule
